// File: rtl/command_vars.sv
// Shared command definitions for the SPI NAND command path.
// Holds the mem_command command encoding, the feature-register constants
// used when polling, the program-sequence status codes, and the state and
// step encodings used by nand_prog_seq.
package command_vars;

  typedef enum logic [3:0] {
    NO_COMMAND      = 4'd0,
    PROG_LOAD1      = 4'd1,
    WRITE_ENABLE    = 4'd2,
    PROGRAM_EXECUTE = 4'd3,
    GET_FEATURE     = 4'd4
  } SPI_Command;

  // Status feature register address and the bits read from it
  localparam logic [7:0] FEAT_STATUS = 8'hC0;
  localparam int         OIP_BIT     = 0;
  localparam int         PFAIL_BIT   = 3;

  // Program-sequence result codes
  localparam logic [1:0] ST_PASS    = 2'b00;
  localparam logic [1:0] ST_PFAIL   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_PROTO   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_RDY,
    S_GAP,
    S_EVAL,
    S_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    STEP_LOAD,
    STEP_WREN,
    STEP_EXEC,
    STEP_POLL
  } seq_step_t;

endpackage

// File: rtl/nand_prog_seq_cycle_timer.sv
// cycle_timer: loadable down-counter with a single-cycle expire pulse.
// Ports:
//   i_Clk, i_Rst_L  clock, asynchronous active-low reset
//   i_Load          load i_Load_Val into the counter (wins over i_En)
//   i_Load_Val      number of enabled cycles until expiry
//   i_En            count this cycle
//   o_Expire        high during the last enabled cycle of the loaded count
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         i_Clk,
  input  logic         i_Rst_L,
  input  logic         i_Load,
  input  logic [W-1:0] i_Load_Val,
  input  logic         i_En,
  output logic         o_Expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_Load) begin
      cnt_d = i_Load_Val;
    end else if (i_En && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A load of N expires on the Nth enabled cycle, so the owner sees exactly
  // N cycles in its counting state.
  assign o_Expire = i_En && (cnt_q == W'(1));

endmodule

// File: rtl/nand_prog_seq.sv
// nand_prog_seq: drives mem_command to program one SPI NAND page.
// Issues PROG_LOAD1, WRITE_ENABLE, PROGRAM_EXECUTE, then polls GET_FEATURE
// on the status register until OIP clears, and reports the result.
// Ports:
//   i_Clk, i_Rst_L          clock, asynchronous active-low reset
//   i_Start                 start request (only honoured when idle)
//   i_Column, i_Row         page column / row address, latched on start
//   o_Busy, o_Done          sequence busy, one-cycle completion pulse
//   o_Status                00 pass, 01 P_FAIL, 10 timeout, 11 protocol error
//   o_Command, o_CM_DV,
//   o_Addr_Data             command port towards mem_command
//   i_CM_Ready              mem_command ready
//   i_RX_Feature_Byte/_DV   feature byte returned by GET_FEATURE
module nand_prog_seq
  import command_vars::*;
#(
  parameter int MAX_POLLS = 64,
  parameter int POLL_GAP  = 100,
  parameter int ACK_WAIT  = 8
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_Start,
  input  logic [12:0] i_Column,
  input  logic [23:0] i_Row,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [1:0]  o_Status,
  output SPI_Command  o_Command,
  output logic        o_CM_DV,
  output logic [23:0] o_Addr_Data,
  input  logic        i_CM_Ready,
  input  logic [7:0]  i_RX_Feature_Byte,
  input  logic        i_RX_Feature_DV
);

  localparam int T_MAX = (ACK_WAIT > POLL_GAP) ? ACK_WAIT : POLL_GAP;
  localparam int TW    = $clog2(T_MAX + 1);

  seq_state_t  state_q, state_d;
  seq_step_t   step_q, step_d;
  logic [7:0]  poll_cnt_q, poll_cnt_d;
  logic [12:0] col_q, col_d;
  logic [23:0] row_q, row_d;
  logic [7:0]  feat_q, feat_d;
  logic        got_byte_q, got_byte_d;
  logic [1:0]  status_q, status_d;
  SPI_Command  cmd_q, cmd_d;
  logic        dv_q, dv_d;
  logic [23:0] addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_en;
  logic          tmr_expire;

  // One timer serves both the ack window and the poll gap; the two never
  // overlap because each is owned by a different state.
  cycle_timer #(.W(TW)) u_timer (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Load     (tmr_load),
    .i_Load_Val (tmr_val),
    .i_En       (tmr_en),
    .o_Expire   (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    poll_cnt_d = poll_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    feat_d     = feat_q;
    got_byte_d = got_byte_q;
    status_d   = status_q;
    cmd_d      = NO_COMMAND;
    addr_d     = '0;
    dv_d       = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_en     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          col_d      = i_Column;
          row_d      = i_Row;
          step_d     = STEP_LOAD;
          poll_cnt_d = '0;
          got_byte_d = 1'b0;
          status_d   = ST_PASS;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (i_CM_Ready) begin
          dv_d     = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TW'(ACK_WAIT);
          state_d  = S_WAIT_ACK;
          unique case (step_q)
            STEP_LOAD: begin
              cmd_d  = PROG_LOAD1;
              addr_d = {11'b0, col_q};
            end
            STEP_WREN: begin
              cmd_d  = WRITE_ENABLE;
              addr_d = '0;
            end
            STEP_EXEC: begin
              cmd_d  = PROGRAM_EXECUTE;
              addr_d = row_q;
            end
            STEP_POLL: begin
              cmd_d  = GET_FEATURE;
              addr_d = {8'h00, FEAT_STATUS, 8'h00};
            end
          endcase
        end
      end

      S_WAIT_ACK: begin
        tmr_en = 1'b1;
        // A late ack arriving on the expiry cycle still counts as an ack.
        if (!i_CM_Ready) begin
          state_d = S_WAIT_RDY;
        end else if (tmr_expire) begin
          status_d = ST_PROTO;
          state_d  = S_DONE;
        end
      end

      S_WAIT_RDY: begin
        // Captured even on the cycle ready returns.
        if ((step_q == STEP_POLL) && i_RX_Feature_DV) begin
          feat_d     = i_RX_Feature_Byte;
          got_byte_d = 1'b1;
        end
        if (i_CM_Ready) begin
          unique case (step_q)
            STEP_LOAD: begin
              step_d  = STEP_WREN;
              state_d = S_ISSUE;
            end
            STEP_WREN: begin
              step_d  = STEP_EXEC;
              state_d = S_ISSUE;
            end
            STEP_EXEC: begin
              step_d  = STEP_POLL;
              state_d = S_ISSUE;
            end
            STEP_POLL: begin
              state_d = S_EVAL;
            end
          endcase
        end
      end

      S_EVAL: begin
        if (!got_byte_q) begin
          status_d = ST_PROTO;
          state_d  = S_DONE;
        end else if (!feat_q[OIP_BIT]) begin
          status_d = feat_q[PFAIL_BIT] ? ST_PFAIL : ST_PASS;
          state_d  = S_DONE;
        end else if ((poll_cnt_q + 8'd1) == 8'(MAX_POLLS)) begin
          status_d = ST_TIMEOUT;
          state_d  = S_DONE;
        end else begin
          poll_cnt_d = poll_cnt_q + 8'd1;
          tmr_load   = 1'b1;
          tmr_val    = TW'(POLL_GAP);
          state_d    = S_GAP;
        end
      end

      S_GAP: begin
        tmr_en = 1'b1;
        if (tmr_expire) begin
          got_byte_d = 1'b0;
          state_d    = S_ISSUE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Busy/Done are registered copies of where the FSM is heading, so they
    // line up with the state register without a combinational output path.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= S_IDLE;
      step_q     <= STEP_LOAD;
      poll_cnt_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      feat_q     <= '0;
      got_byte_q <= 1'b0;
      status_q   <= ST_PASS;
      cmd_q      <= NO_COMMAND;
      dv_q       <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      poll_cnt_q <= poll_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      feat_q     <= feat_d;
      got_byte_q <= got_byte_d;
      status_q   <= status_d;
      cmd_q      <= cmd_d;
      dv_q       <= dv_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Only OIP and P_FAIL drive decisions; the rest of the byte is kept whole
  // so it is easy to inspect when debugging.
  logic feat_unused;
  assign feat_unused = ^{feat_q[7:4], feat_q[2:1]};

  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_Status    = status_q;
  assign o_Command   = cmd_q;
  assign o_CM_DV     = dv_q;
  assign o_Addr_Data = addr_q;

endmodule

// File: tb/tb_nand_prog_seq.sv
// Self-checking bench for nand_prog_seq: a behavioural mem_command responder
// plus a transaction-level reference model of the program sequence.
module tb_nand_prog_seq;
  import command_vars::*;

  localparam int MP = 4;
  localparam int PG = 5;
  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_Start = 1'b0;
  logic [12:0] i_Column = '0;
  logic [23:0] i_Row = '0;
  logic        cm_ready = 1'b1;
  logic [7:0]  feat_byte = '0;
  logic        feat_dv = 1'b0;
  logic        dut_busy, dut_done, dut_dv;
  logic [1:0]  dut_status;
  logic [23:0] dut_addr;
  SPI_Command  dut_cmd;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // responder configuration
  bit ack_en = 1'b1, feat_en = 1'b1, feat_early = 1'b0, force_low = 1'b0;
  int fall_dly = 1, busy_len = 20;
  logic [7:0] feat_q[$];
  logic [7:0] exp_bytes [MP];

  // observed command stream
  SPI_Command  cmd_q[$];
  logic [23:0] addr_q[$];
  int          cyc_q[$];

  nand_prog_seq #(.MAX_POLLS(MP), .POLL_GAP(PG), .ACK_WAIT(AW)) dut (
    .i_Clk             (clk),
    .i_Rst_L           (rst_n),
    .i_Start           (i_Start),
    .i_Column          (i_Column),
    .i_Row             (i_Row),
    .o_Busy            (dut_busy),
    .o_Done            (dut_done),
    .o_Status          (dut_status),
    .o_Command         (dut_cmd),
    .o_CM_DV           (dut_dv),
    .o_Addr_Data       (dut_addr),
    .i_CM_Ready        (cm_ready),
    .i_RX_Feature_Byte (feat_byte),
    .i_RX_Feature_DV   (feat_dv)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // mem_command model: ready drops fall_dly cycles after a DV, stays low
  // busy_len cycles; a GET_FEATURE returns its byte as ready comes back
  // (or one cycle earlier when feat_early is set).
  initial begin : responder
    int  fall_cnt, busy_cnt;
    bit  prev_dv;
    SPI_Command last_cmd;
    fall_cnt = 0; busy_cnt = 0; prev_dv = 1'b0; last_cmd = NO_COMMAND;
    forever begin
      @(negedge clk);
      feat_dv = 1'b0;
      if (!rst_n) begin
        fall_cnt = 0; busy_cnt = 0; prev_dv = 1'b0; cm_ready = 1'b1;
      end else begin
        if (dut_dv) begin
          chk("dv_while_not_ready", cm_ready, 1);
          chk("dv_back_to_back", prev_dv, 0);
          cmd_q.push_back(dut_cmd);
          addr_q.push_back(dut_addr);
          cyc_q.push_back(cyc);
          last_cmd = dut_cmd;
          if (ack_en) fall_cnt = fall_dly;
        end else if (fall_cnt > 0) begin
          fall_cnt--;
          if (fall_cnt == 0) begin
            cm_ready = 1'b0;
            busy_cnt = busy_len;
          end
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (last_cmd == GET_FEATURE && feat_en && busy_cnt == (feat_early ? 1 : 0)) begin
            feat_dv   = 1'b1;
            feat_byte = (feat_q.size() > 0) ? feat_q.pop_front() : 8'h01;
          end
          if (busy_cnt == 0) cm_ready = 1'b1;
        end
        if (force_low) cm_ready = 1'b0;
        else if (fall_cnt == 0 && busy_cnt == 0) cm_ready = 1'b1;
        prev_dv = dut_dv;
      end
    end
  end

  // Reference: which result and how many polls the device answers produce.
  function automatic void model(output int n_polls, output int st, output int n_cmds);
    if (!ack_en) begin
      n_polls = 0; st = 3; n_cmds = 1;
      return;
    end
    if (!feat_en) begin
      n_polls = 1; st = 3; n_cmds = 4;
      return;
    end
    n_polls = MP; st = 2;
    for (int i = 0; i < MP; i++) begin
      if (exp_bytes[i][0] == 1'b0) begin
        n_polls = i + 1;
        st = exp_bytes[i][3] ? 1 : 0;
        break;
      end
    end
    n_cmds = 3 + n_polls;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, dut_busy, 0);
    chk({tag, "_done"}, dut_done, 0);
    chk({tag, "_status"}, dut_status, 0);
    chk({tag, "_dv"}, dut_dv, 0);
    chk({tag, "_cmd"}, 32'(dut_cmd), 32'(NO_COMMAND));
    chk({tag, "_addr"}, dut_addr, 0);
  endtask

  task automatic run_txn(input logic [12:0] col, input logic [23:0] row,
                         input bit stall, input bit glitch);
    int np, st, nc, t0, n, done_cyc;
    bit gl;
    logic [23:0] want_addr;
    SPI_Command  want_cmd;
    model(np, st, nc);
    cmd_q.delete(); addr_q.delete(); cyc_q.delete(); feat_q.delete();
    for (int i = 0; i < MP; i++) feat_q.push_back(exp_bytes[i]);
    force_low = stall;
    @(negedge clk);
    i_Start = 1'b1; i_Column = col; i_Row = row; t0 = cyc;
    @(negedge clk);
    i_Start = 1'b0; i_Column = 13'($urandom); i_Row = 24'($urandom);
    n = 0; gl = 1'b0;
    while (!dut_done && n < 3000) begin
      if (stall && n == 50) begin
        chk("stall_no_dv", cmd_q.size(), 0);
        force_low = 1'b0;
      end
      i_Start = 1'b0;
      if (glitch && !gl && cmd_q.size() >= 1) begin
        i_Start = 1'b1; i_Column = 13'($urandom); i_Row = 24'($urandom);
        gl = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    i_Start = 1'b0;
    force_low = 1'b0;
    done_cyc = cyc;
    chk("done_seen", dut_done, 1);
    if (!dut_done) begin
      rst_n = 1'b0; repeat (2) @(negedge clk); rst_n = 1'b1;
      return;
    end
    chk("status", dut_status, st);
    chk("busy_at_done", dut_busy, 1);
    chk("num_cmds", cmd_q.size(), nc);
    if (cmd_q.size() > 0) begin
      if (stall) chk("stall_dv_after_release", cyc_q[0] > t0 + 50, 1);
      else chk("start_to_dv", cyc_q[0] - t0, 2);
      if (!ack_en) chk("ack_timeout_len", done_cyc - cyc_q[0], AW);
    end
    for (int i = 0; i < cmd_q.size() && i < nc; i++) begin
      case (i)
        0: begin want_cmd = PROG_LOAD1;      want_addr = {11'b0, col}; end
        1: begin want_cmd = WRITE_ENABLE;    want_addr = 24'h0; end
        2: begin want_cmd = PROGRAM_EXECUTE; want_addr = row; end
        default: begin want_cmd = GET_FEATURE; want_addr = 24'h00C000; end
      endcase
      chk($sformatf("cmd%0d", i), 32'(cmd_q[i]), 32'(want_cmd));
      chk($sformatf("addr%0d", i), addr_q[i], want_addr);
      if (i >= 4) chk("poll_spacing", (cyc_q[i] - cyc_q[i-1]) >= PG + 3, 1);
    end
    @(negedge clk);
    chk("busy_after_done", dut_busy, 0);
    chk("done_one_cycle", dut_done, 0);
  endtask

  task automatic set_bytes(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    exp_bytes[0] = b0; exp_bytes[1] = b1; exp_bytes[2] = b2; exp_bytes[3] = b3;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    logic [7:0] b;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // nominal pass
    fall_dly = 1; busy_len = 20; feat_early = 1'b0;
    set_bytes(8'h01, 8'h01, 8'h00, 8'h00);
    run_txn(13'h034, 24'h000100, 1'b0, 1'b0);

    // program fail on first poll
    set_bytes(8'h08, 8'h01, 8'h01, 8'h01);
    run_txn(13'h1ABC, 24'h123456, 1'b0, 1'b0);

    // poll timeout
    set_bytes(8'h01, 8'h01, 8'h01, 8'h01);
    run_txn(13'h0007, 24'hABCDEF, 1'b0, 1'b0);

    // no ack after LOAD
    ack_en = 1'b0;
    run_txn(13'h0100, 24'h000001, 1'b0, 1'b0);
    ack_en = 1'b1;

    // poll returns no feature byte
    feat_en = 1'b0;
    run_txn(13'h0200, 24'h000002, 1'b0, 1'b0);
    feat_en = 1'b1;

    // ready stalled in ISSUE, plus a start while busy
    set_bytes(8'h01, 8'h00, 8'h01, 8'h01);
    run_txn(13'h0ABC, 24'h5A5A5A, 1'b1, 1'b1);

    // reset during EXEC wait-ready
    set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
    cmd_q.delete(); addr_q.delete(); cyc_q.delete();
    busy_len = 20;
    @(negedge clk);
    i_Start = 1'b1; i_Column = 13'h0055; i_Row = 24'h000777;
    @(negedge clk);
    i_Start = 1'b0;
    n = 0;
    while (!(cmd_q.size() == 3 && !cm_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reached_exec_wait", cmd_q.size(), 3);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midop_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_in_reset", dut_done, 0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_done_after_reset", dut_done, 0);
    set_bytes(8'h01, 8'h01, 8'h00, 8'h00);
    run_txn(13'h034, 24'h000100, 1'b0, 1'b0);

    // randomized transactions
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < MP; i++) begin
        b = 8'($urandom);
        b[0] = ($urandom_range(0, 99) < 65);
        exp_bytes[i] = b;
      end
      fall_dly   = $urandom_range(1, 4);
      busy_len   = $urandom_range(2, 20);
      feat_early = 1'($urandom_range(0, 1));
      run_txn(13'($urandom), 24'($urandom), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/nand_prog_seq.md
# nand_prog_seq

Command sequencer that sits directly upstream of `mem_command` and drives its command port to program one SPI NAND page. On a start request it issues PROG_LOAD1, WRITE_ENABLE, PROGRAM_EXECUTE, then polls GET_FEATURE on the status register until the operation-in-progress bit clears, and reports pass, program-fail or timeout. It replaces the ad-hoc command stepping in the top-level FIFO state machine. Page data is supplied by `mem_command`'s internal FIFO during PROG_LOAD1.

## Interface
- `MAX_POLLS`, 64: GET_FEATURE attempts before timeout, 1..255.
- `POLL_GAP`, 100: idle i_Clk cycles between successive polls, ≥1.
- `ACK_WAIT`, 8: cycles allowed for `i_CM_Ready` to fall after a DV pulse.
- `i_Clk`  in  1  clock, the divided system clock.
- `i_Rst_L`  in  1  asynchronous active-low reset.
- `i_Start`  in  1  one-cycle start request; sampled only in IDLE.
- `i_Column`  in  13  column address for PROG_LOAD1.
- `i_Row`  in  24  row/page address for PROGRAM_EXECUTE.
- `o_Busy`  out  1  high from accepted start through the DONE cycle.
- `o_Done`  out  1  one-cycle completion pulse.
- `o_Status`  out  2  00 pass, 01 P_FAIL, 10 poll timeout, 11 protocol error. Valid with `o_Done` and held until the next accepted start.
- `o_Command`  out  SPI_Command  command to `mem_command`.
- `o_CM_DV`  out  1  command valid pulse.
- `o_Addr_Data`  out  24  address/data field for the command.
- `i_CM_Ready`  in  1  `mem_command` ready.
- `i_RX_Feature_Byte`  in  8  returned feature byte.
- `i_RX_Feature_DV`  in  1  feature byte valid pulse.

## Operation
- **States:** IDLE, ISSUE, WAIT_ACK, WAIT_RDY, GAP, EVAL, DONE. A 2-bit step register selects the command: LOAD, WREN, EXEC, POLL.
- **IDLE**
  - `i_Start` latches `i_Column`/`i_Row`, sets step=LOAD, clears the poll counter, and moves to ISSUE.
  - `i_Start` in any other state is ignored.
- **ISSUE**
  - Waits for `i_CM_Ready`=1, then drives `o_Command`/`o_Addr_Data` with `o_CM_DV`=1 for exactly one cycle, and moves to WAIT_ACK.
  - `o_Addr_Data` per step:
    - LOAD: `{11'b0, column}`.
    - WREN: 0.
    - EXEC: row.
    - POLL: `[15:8]`=8'hC0, other bits 0.
- **WAIT_ACK:** waits for `i_CM_Ready`=0, then moves to WAIT_RDY. If `ACK_WAIT` cycles elapse first, the result is status 11 and the FSM goes to DONE.
- **WAIT_RDY**
  - Waits for `i_CM_Ready`=1.
  - While step=POLL, any `i_RX_Feature_DV` captures the byte and sets a got-byte flag.
  - On ready: step LOAD→WREN→EXEC→POLL, each followed by ISSUE. At step POLL the FSM moves to EVAL instead.
- **EVAL**
  - got-byte=0: status 11, go to DONE.
  - Byte bit0 (OIP)=0: status is bit3 (P_FAIL) ? 01 : 00; go to DONE.
  - OIP=1 and poll count+1 = `MAX_POLLS`: status 10, go to DONE.
  - Otherwise increment the poll count and go to GAP.
- **GAP:** counts `POLL_GAP` cycles, clears got-byte, then returns to ISSUE (step POLL).
- **DONE:** `o_Done`=1 for one cycle, then IDLE.
- **Width rules:** the poll counter is 8 bits; the gap and ack counters are sized by `$clog2` of their parameters.

## Timing
- **Reset values:** state IDLE, `o_Busy` 0, `o_Done` 0, `o_Status` 00, `o_Command` NO_COMMAND, `o_CM_DV` 0, `o_Addr_Data` 0.
- **Reset mid-operation:** everything returns to the reset values at once. A command already pulsed is abandoned. No `o_Done` is generated.
- **Start to first DV:** if `i_CM_Ready`=1, `o_CM_DV` asserts in the 2nd cycle after the `i_Start` cycle.
- **DV rules:** never asserted on consecutive cycles, and never while `i_CM_Ready`=0.
- **Feature byte timing:** a byte arriving in the same cycle `i_CM_Ready` rises is still captured.
- **Poll spacing:** consecutive GET_FEATURE DV pulses are ≥ `POLL_GAP`+3 cycles apart.
- **Busy/Done:** `o_Busy` is registered and deasserts the cycle after `o_Done`.

## Structure
- Add to the shared `command_vars` package: the `SPI_Command` enum values PROG_LOAD1, WRITE_ENABLE, PROGRAM_EXECUTE, GET_FEATURE, NO_COMMAND; localparams `FEAT_STATUS`=8'hC0, `OIP_BIT`=0, `PFAIL_BIT`=3; and the status code constants.
- The FSM and the step, poll and latch registers stay in `nand_prog_seq`.
- One sub-module, `cycle_timer` (load value, count down, expire pulse), is shared by the ACK_WAIT and POLL_GAP counting.

## Test plan
- **Nominal pass:** column 0x034, row 0x000100; model ready falls 1 cycle after DV and returns after 20 cycles; feature bytes 0x01, 0x01, 0x00 → command order LOAD/WREN/EXEC/GETF×3, `o_Addr_Data` 0x000034, 0, 0x000100, 0x00C000; status 00.
- **Program fail:** final feature byte 0x08 → status 01 after the first poll.
- **Timeout:** `MAX_POLLS`=4, all feature bytes 0x01 → exactly 4 GET_FEATURE issues, status 10, 4 gaps minus one observed.
- **Protocol error:** ready never falls after the LOAD DV → status 11 after `ACK_WAIT`; separately, POLL with no `i_RX_Feature_DV` → status 11.
- **Ignored start and stall:** `i_Start` pulsed while Busy → ignored and latched addresses unchanged; `i_CM_Ready` held 0 in ISSUE for 50 cycles → no DV until ready.
- **Reset mid-operation:** `i_Rst_L` low during EXEC WAIT_RDY → all outputs reach reset values immediately; the next start runs a clean full sequence.
